// File: rtl/tt_scanner.sv
// tt_scanner: sweeps a 4-input stimulus vector over all 16 indices, captures the
// truth tables of two function implementations, and compares them against each
// other and against expected tables.
module tt_scanner #(
    parameter logic [15:0] EXP_A  = 16'hF272,
    parameter logic [15:0] EXP_B  = 16'hF266,
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        resp_a,
    input  logic        resp_b,
    output logic [3:0]  x,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_a,
    output logic [15:0] table_b,
    output logic        res_valid,
    output logic        pass_a,
    output logic        pass_b,
    output logic [4:0]  mis_cnt,
    output logic        mis_found,
    output logic [3:0]  first_mis
);

    localparam int unsigned CW = 4;
    localparam int unsigned XW = 4;
    localparam int unsigned TW = 16;
    localparam int unsigned MW = 5;

    localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
    localparam logic [XW-1:0] X_LAST   = XW'(15);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [XW-1:0]   x_n;
    logic            busy_n, done_n, res_valid_n, pass_a_n, pass_b_n, mis_found_n;
    logic [TW-1:0]   table_a_n, table_b_n;
    logic [MW-1:0]   mis_cnt_n;
    logic [XW-1:0]   first_mis_n;

    // Register state and every output; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            x         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_a   <= '0;
            table_b   <= '0;
            res_valid <= 1'b0;
            pass_a    <= 1'b0;
            pass_b    <= 1'b0;
            mis_cnt   <= '0;
            mis_found <= 1'b0;
            first_mis <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            x         <= x_n;
            busy      <= busy_n;
            done      <= done_n;
            table_a   <= table_a_n;
            table_b   <= table_b_n;
            res_valid <= res_valid_n;
            pass_a    <= pass_a_n;
            pass_b    <= pass_b_n;
            mis_cnt   <= mis_cnt_n;
            mis_found <= mis_found_n;
            first_mis <= first_mis_n;
        end
    end

    // Next-state and next-output logic; everything holds unless a state acts.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        x_n         = x;
        busy_n      = busy;
        done_n      = 1'b0;
        table_a_n   = table_a;
        table_b_n   = table_b;
        res_valid_n = res_valid;
        pass_a_n    = pass_a;
        pass_b_n    = pass_b;
        mis_cnt_n   = mis_cnt;
        mis_found_n = mis_found;
        first_mis_n = first_mis;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n     = S_SWEEP;
                    cnt_n       = '0;
                    x_n         = '0;
                    busy_n      = 1'b1;
                    table_a_n   = '0;
                    table_b_n   = '0;
                    res_valid_n = 1'b0;
                    pass_a_n    = 1'b0;
                    pass_b_n    = 1'b0;
                    mis_cnt_n   = '0;
                    mis_found_n = 1'b0;
                    first_mis_n = '0;
                end
            end

            S_SWEEP: begin
                if (cnt == SETTLE_C) begin
                    // Vector has settled: capture both responses at index x.
                    table_a_n[x] = resp_a;
                    table_b_n[x] = resp_b;
                    if (resp_a != resp_b) begin
                        mis_cnt_n = mis_cnt + MW'(1);
                        if (!mis_found) begin
                            mis_found_n = 1'b1;
                            first_mis_n = x;
                        end
                    end
                    if (x != X_LAST) begin
                        x_n   = x + XW'(1);
                        cnt_n = '0;
                    end else begin
                        state_n     = S_DONE;
                        busy_n      = 1'b0;
                        done_n      = 1'b1;
                        res_valid_n = 1'b1;
                        pass_a_n    = (table_a_n == EXP_A);
                        pass_b_n    = (table_b_n == EXP_B);
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end

            S_DONE: begin
                state_n = S_IDLE;
                x_n     = '0;
            end

            default: begin
                state_n = S_IDLE;
                x_n     = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_tt_scanner.sv
// Scoreboard bench for tt_scanner: directed sweeps on a SETTLE=1 and a SETTLE=3
// instance; expected results are queued at start and checked on each done pulse.
module tb_tt_scanner;

    localparam logic [15:0] B_TT = 16'hF266;

    typedef struct {
        logic [15:0] ta;
        logic [15:0] tb;
        logic        pa;
        logic        pb;
        logic [4:0]  mc;
        logic        mf;
        logic [3:0]  fm;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int mode     = 0;

    // SETTLE=1 instance signals
    logic        start_1 = 1'b0;
    logic        ra_1, rb_1;
    logic [3:0]  x_1;
    logic        busy_1, done_1, rv_1, pa_1, pb_1, mf_1;
    logic [15:0] ta_1, tb_1;
    logic [4:0]  mc_1;
    logic [3:0]  fm_1;

    // SETTLE=3 instance signals
    logic        start_3 = 1'b0;
    logic        ra_3, rb_3;
    logic [3:0]  x_3;
    logic        busy_3, done_3, rv_3, pa_3, pb_3, mf_3;
    logic [15:0] ta_3, tb_3;
    logic [4:0]  mc_3;
    logic [3:0]  fm_3;

    exp_t q1[$];
    exp_t q3[$];
    int   bc1 = 0;
    int   bc3 = 0;

    tt_scanner #(.EXP_A(16'hF272), .EXP_B(16'hF266), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_1), .resp_a(ra_1), .resp_b(rb_1),
        .x(x_1), .busy(busy_1), .done(done_1), .table_a(ta_1), .table_b(tb_1),
        .res_valid(rv_1), .pass_a(pa_1), .pass_b(pb_1), .mis_cnt(mc_1),
        .mis_found(mf_1), .first_mis(fm_1)
    );

    tt_scanner #(.EXP_A(16'hF272), .EXP_B(16'hF266), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_3), .resp_a(ra_3), .resp_b(rb_3),
        .x(x_3), .busy(busy_3), .done(done_3), .table_a(ta_3), .table_b(tb_3),
        .res_valid(rv_3), .pass_a(pa_3), .pass_b(pb_3), .mis_cnt(mc_3),
        .mis_found(mf_3), .first_mis(fm_3)
    );

    function automatic logic sop(input logic [3:0] v);
        return (!v[3] & v[2] & !v[0]) | (v[3] & v[2]) | (!v[1] & v[0]);
    endfunction

    // Function implementations under test, driven from the stimulus vector.
    always_comb begin
        logic [15:0] btab;
        btab = B_TT;
        ra_1 = 1'b0;
        rb_1 = 1'b0;
        case (mode)
            0: begin ra_1 = sop(x_1); rb_1 = btab[x_1]; end
            1: begin ra_1 = 1'b0;     rb_1 = 1'b1;      end
            default: begin ra_1 = 1'b0; rb_1 = 1'b0; end
        endcase
        ra_3 = x_3[0];
        rb_3 = x_3[0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the SETTLE=1 instance: compare on each done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (done_1) begin
            if (q1.size() == 0) begin
                check("d1_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                check("d1_table_a",   32'(ta_1), 32'(e.ta));
                check("d1_table_b",   32'(tb_1), 32'(e.tb));
                check("d1_pass_a",    32'(pa_1), 32'(e.pa));
                check("d1_pass_b",    32'(pb_1), 32'(e.pb));
                check("d1_mis_cnt",   32'(mc_1), 32'(e.mc));
                check("d1_mis_found", 32'(mf_1), 32'(e.mf));
                if (e.mf) check("d1_first_mis", 32'(fm_1), 32'(e.fm));
                check("d1_sweep_len", 32'(bc1), 32'(e.cyc));
                check("d1_done_busy", 32'(busy_1), 32'd0);
                check("d1_done_rv",   32'(rv_1), 32'd1);
                check("d1_done_x",    32'(x_1), 32'd15);
            end
            bc1 = 0;
        end else if (busy_1) begin
            bc1++;
        end else begin
            bc1 = 0;
        end
    end

    // Monitor for the SETTLE=3 instance.
    always @(negedge clk) begin
        exp_t e;
        if (done_3) begin
            if (q3.size() == 0) begin
                check("d3_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q3.pop_front();
                check("d3_table_a",   32'(ta_3), 32'(e.ta));
                check("d3_table_b",   32'(tb_3), 32'(e.tb));
                check("d3_pass_a",    32'(pa_3), 32'(e.pa));
                check("d3_pass_b",    32'(pb_3), 32'(e.pb));
                check("d3_mis_cnt",   32'(mc_3), 32'(e.mc));
                check("d3_mis_found", 32'(mf_3), 32'(e.mf));
                check("d3_sweep_len", 32'(bc3), 32'(e.cyc));
            end
            bc3 = 0;
        end else if (busy_3) begin
            bc3++;
        end else begin
            bc3 = 0;
        end
    end

    task automatic check_reset_1(input string tag);
        check({tag, "_x"},       32'(x_1),  32'd0);
        check({tag, "_busy"},    32'(busy_1), 32'd0);
        check({tag, "_done"},    32'(done_1), 32'd0);
        check({tag, "_table_a"}, 32'(ta_1), 32'd0);
        check({tag, "_table_b"}, 32'(tb_1), 32'd0);
        check({tag, "_rv"},      32'(rv_1), 32'd0);
        check({tag, "_pass_a"},  32'(pa_1), 32'd0);
        check({tag, "_pass_b"},  32'(pb_1), 32'd0);
        check({tag, "_mis_cnt"}, 32'(mc_1), 32'd0);
        check({tag, "_mis_fnd"}, 32'(mf_1), 32'd0);
        check({tag, "_first"},   32'(fm_1), 32'd0);
    endtask

    task automatic wait_done_1(input string tag);
        int k;
        k = 0;
        while (!done_1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!done_1) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic push1(input logic [15:0] ta, input logic [15:0] tb, input logic pa,
                         input logic pb, input logic [4:0] mc, input logic mf,
                         input logic [3:0] fm);
        exp_t e;
        e.ta = ta; e.tb = tb; e.pa = pa; e.pb = pb;
        e.mc = mc; e.mf = mf; e.fm = fm; e.cyc = 32;
        q1.push_back(e);
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e3;
        int   k;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_reset_1("rst");
        check("rst_d3_busy", 32'(busy_3), 32'd0);
        check("rst_d3_x",    32'(x_3),    32'd0);

        // Ideal SOP/POS pair: mismatches at indices 2 and 4.
        mode = 0;
        push1(16'hF272, 16'hF266, 1'b1, 1'b1, 5'd2, 1'b1, 4'd2);
        start_1 = 1'b1;
        @(negedge clk);
        start_1 = 1'b0;
        check("t1_busy_first", 32'(busy_1), 32'd1);
        check("t1_x_first",    32'(x_1),    32'd0);
        wait_done_1("t1");
        repeat (3) @(negedge clk);
        check("t1_idle_x",    32'(x_1),  32'd0);
        check("t1_idle_rv",   32'(rv_1), 32'd1);
        check("t1_idle_ta",   32'(ta_1), 32'hF272);
        check("t1_idle_pa",   32'(pa_1), 32'd1);
        check("t1_idle_busy", 32'(busy_1), 32'd0);

        // Stuck responses: every index disagrees.
        mode = 1;
        push1(16'h0000, 16'hFFFF, 1'b0, 1'b0, 5'd16, 1'b1, 4'd0);
        start_1 = 1'b1;
        @(negedge clk);
        start_1 = 1'b0;
        check("t2_rv_cleared", 32'(rv_1), 32'd0);
        check("t2_pa_gated",   32'(pa_1), 32'd0);
        check("t2_mc_cleared", 32'(mc_1), 32'd0);
        wait_done_1("t2");
        @(negedge clk);

        // start held high through the sweep and the done cycle: one sweep only.
        mode = 0;
        push1(16'hF272, 16'hF266, 1'b1, 1'b1, 5'd2, 1'b1, 4'd2);
        start_1 = 1'b1;
        @(negedge clk);
        wait_done_1("t3");
        @(negedge clk);
        start_1 = 1'b0;
        check("t3_idle_after_done", 32'(busy_1), 32'd0);
        repeat (4) @(negedge clk);
        check("t3_no_requeue", 32'(busy_1), 32'd0);
        check("t3_q_empty",    32'(q1.size()), 32'd0);

        // Reset mid-sweep at x=7, then restart on the first cycle after release.
        start_1 = 1'b1;
        @(negedge clk);
        start_1 = 1'b0;
        k = 0;
        while (x_1 != 4'd7 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t4_reached_x7", 32'(x_1), 32'd7);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_1("t4_rst");
        push1(16'hF272, 16'hF266, 1'b1, 1'b1, 5'd2, 1'b1, 4'd2);
        start_1 = 1'b1;
        @(negedge clk);
        start_1 = 1'b0;
        check("t4_restart_busy", 32'(busy_1), 32'd1);
        wait_done_1("t4");
        @(negedge clk);

        // SETTLE=3: each vector held 4 cycles, tables follow x[0].
        e3.ta = 16'hAAAA; e3.tb = 16'hAAAA; e3.pa = 1'b0; e3.pb = 1'b0;
        e3.mc = 5'd0; e3.mf = 1'b0; e3.fm = 4'd0; e3.cyc = 64;
        q3.push_back(e3);
        start_3 = 1'b1;
        @(negedge clk);
        start_3 = 1'b0;
        for (int c = 0; c < 64; c++) begin
            check("t5_x_hold", 32'(x_3), 32'(c / 4));
            @(negedge clk);
        end
        check("t5_done_at_64", 32'(done_3), 32'd1);
        repeat (2) @(negedge clk);

        check("end_q1_empty", 32'(q1.size()), 32'd0);
        check("end_q3_empty", 32'(q3.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
